uart_tx_framer: RTL and testbench

Byte-serial UART transmitter that consumes the bit-period strobe of the shared flexcounter and drives the board TX line. It buffers bytes from the keystroke/encode path in a small FIFO and frames each as start bit, 8 data bits (LSB first), optional parity, and 1 or 2 stop bits. It owns the counter's enable, so the bit phase restarts cleanly at the beginning of every idle-to-active transition.

---
 rtl/uart_tx_framer.sv | 136 +++++++++++++
 tb/tb_uart_tx_framer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_framer.sv
// UART transmitter: small byte FIFO feeding a start/data/parity/stop framer.
// Owns the shared baud counter's enable so each burst begins on a full bit period.
module uart_tx_framer #(
  parameter int DEPTH      = 4,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic       clk,
  input  logic       RST,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       baud_strobe,
  output logic       baud_enable,
  output logic       tx,
  output logic       busy
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t        state, state_n;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_n;
  logic [7:0]    shift, shift_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic          acc, acc_n;
  logic          stop_cnt, stop_cnt_n;
  logic          push, pop, full, empty;
  logic          tx_d, be_d, busy_d;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign in_ready = !full;
  assign push     = in_valid && !full;
  assign count_n  = count + (AW+1)'(push) - (AW+1)'(pop);

  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= in_data;

  // Framer state register; pointers are power-of-two sized so they wrap naturally.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      shift    <= '0;
      bit_idx  <= '0;
      acc      <= 1'b0;
      stop_cnt <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      state    <= state_n;
      shift    <= shift_n;
      bit_idx  <= bit_idx_n;
      acc      <= acc_n;
      stop_cnt <= stop_cnt_n;
      count    <= count_n;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_comb begin
    state_n    = state;
    shift_n    = shift;
    bit_idx_n  = bit_idx;
    acc_n      = acc;
    stop_cnt_n = stop_cnt;
    pop        = 1'b0;
    case (state)
      IDLE: if (!empty) begin
        pop       = 1'b1;
        shift_n   = mem[rd_ptr];
        bit_idx_n = '0;
        acc_n     = 1'b0;
        state_n   = START;
      end
      START: if (baud_strobe) state_n = DATA;
      DATA: if (baud_strobe) begin
        shift_n   = {1'b0, shift[7:1]};
        acc_n     = acc ^ shift[0];
        bit_idx_n = bit_idx + 3'd1;
        if (bit_idx == 3'd7) begin
          state_n    = (PARITY_EN != 0) ? PARITY : STOP;
          stop_cnt_n = 1'b0;
        end
      end
      PARITY: if (baud_strobe) begin
        state_n    = STOP;
        stop_cnt_n = 1'b0;
      end
      STOP: if (baud_strobe) begin
        if (STOP_BITS == 2 && !stop_cnt) begin
          stop_cnt_n = 1'b1;
        end else if (!empty) begin
          // back-to-back: reload and keep the baud counter running
          pop       = 1'b1;
          shift_n   = mem[rd_ptr];
          bit_idx_n = '0;
          acc_n     = 1'b0;
          state_n   = START;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are decoded from next-state values so the registers line up with state.
  always_comb begin
    be_d   = (state_n != IDLE);
    busy_d = (state_n != IDLE) || (count_n != '0);
    case (state_n)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_n[0];
      PARITY:  tx_d = acc_n ^ (PARITY_ODD != 0);
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      tx          <= 1'b1;
      baud_enable <= 1'b0;
      busy        <= 1'b0;
    end else begin
      tx          <= tx_d;
      baud_enable <= be_d;
      busy        <= busy_d;
    end
  end
endmodule

// File: tb/tb_uart_tx_framer.sv
// Bench for uart_tx_framer: three parameter variants, each paced by a 4-cycle baud counter model.
module tb_uart_tx_framer;
  logic       clk = 1'b0;
  logic       RST;
  logic [7:0] in_data;
  logic [2:0] vld, rdy, stb, be, txw, bsy;
  logic       force_stb;
  logic [1:0] cnt [3];
  int vectors = 0, miscompares = 0;

  typedef struct {
    int          k;
    logic [7:0]  d;
    int          nb;
    logic [11:0] bits;   // bit 0 is sent first
  } vec_t;
  vec_t tbl [10];

  always #5 clk = ~clk;

  // Baud counter with maxCount 4: held at 0 while disabled, strobe on the 4th cycle.
  always @(posedge clk or posedge RST)
    for (int k = 0; k < 3; k++)
      if (RST) cnt[k] <= 2'd0;
      else     cnt[k] <= be[k] ? cnt[k] + 2'd1 : 2'd0;

  always_comb
    for (int k = 0; k < 3; k++)
      stb[k] = (be[k] && cnt[k] == 2'd3) || force_stb;

  uart_tx_framer u0 (
    .clk(clk), .RST(RST), .in_data(in_data), .in_valid(vld[0]), .in_ready(rdy[0]),
    .baud_strobe(stb[0]), .baud_enable(be[0]), .tx(txw[0]), .busy(bsy[0]));

  uart_tx_framer #(.PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u1 (
    .clk(clk), .RST(RST), .in_data(in_data), .in_valid(vld[1]), .in_ready(rdy[1]),
    .baud_strobe(stb[1]), .baud_enable(be[1]), .tx(txw[1]), .busy(bsy[1]));

  uart_tx_framer #(.PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u2 (
    .clk(clk), .RST(RST), .in_data(in_data), .in_valid(vld[2]), .in_ready(rdy[2]),
    .baud_strobe(stb[2]), .baud_enable(be[2]), .tx(txw[2]), .busy(bsy[2]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_raw(input int k, input logic [7:0] d);
    @(negedge clk); in_data = d; vld[k] = 1'b1;
    @(negedge clk); vld[k] = 1'b0;
  endtask

  // Push into an idle DUT and follow the whole frame cycle by cycle.
  task automatic run_frame(input string name, input int k, input logic [7:0] d,
                           input int nb, input logic [11:0] exp);
    logic [11:0] got;
    bit stable;
    got = '0; stable = 1'b1;
    push_raw(k, d);
    check({name, "_launch"}, {txw[k], be[k], bsy[k]}, 3'b101);
    for (int b = 0; b < nb; b++)
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        if (c == 0) got[b] = txw[k];
        else if (txw[k] !== got[b]) stable = 1'b0;
        if (be[k] !== 1'b1) stable = 1'b0;
      end
    check({name, "_bits"}, {stable, got}, {1'b1, exp});
    @(negedge clk);
    check({name, "_end"}, {txw[k], be[k], bsy[k]}, 3'b100);
  endtask

  initial begin
    bit ok;
    RST = 1'b1; vld = '0; in_data = '0; force_stb = 1'b0;

    tbl[0] = '{0, 8'hA5, 10, {2'b00, 1'b1, 8'hA5, 1'b0}};
    tbl[1] = '{0, 8'h00, 10, {2'b00, 1'b1, 8'h00, 1'b0}};
    tbl[2] = '{0, 8'hFF, 10, {2'b00, 1'b1, 8'hFF, 1'b0}};
    tbl[3] = '{0, 8'h3C, 10, {2'b00, 1'b1, 8'h3C, 1'b0}};
    tbl[4] = '{1, 8'h07, 12, {1'b1, 1'b1, 1'b1, 8'h07, 1'b0}};
    tbl[5] = '{1, 8'h00, 12, {1'b1, 1'b1, 1'b0, 8'h00, 1'b0}};
    tbl[6] = '{1, 8'h80, 12, {1'b1, 1'b1, 1'b1, 8'h80, 1'b0}};
    tbl[7] = '{2, 8'h07, 11, {1'b0, 1'b1, 1'b0, 8'h07, 1'b0}};
    tbl[8] = '{2, 8'h00, 11, {1'b0, 1'b1, 1'b1, 8'h00, 1'b0}};
    tbl[9] = '{2, 8'h03, 11, {1'b0, 1'b1, 1'b1, 8'h03, 1'b0}};

    repeat (3) @(negedge clk);
    check("reset_state", {txw, be, bsy, rdy}, {3'b111, 3'b000, 3'b000, 3'b111});
    RST = 1'b0;

    ok = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if (txw !== 3'b111 || be !== 3'b000 || bsy !== 3'b000 || rdy !== 3'b111) ok = 1'b0;
    end
    check("idle_100", ok, 1);

    ok = 1'b1;
    @(negedge clk); force_stb = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (txw !== 3'b111 || be !== 3'b000 || bsy !== 3'b000) ok = 1'b0;
    end
    force_stb = 1'b0;
    check("idle_strobe", ok, 1);

    for (int i = 0; i < 10; i++)
      run_frame($sformatf("vec%0d", i), tbl[i].k, tbl[i].d, tbl[i].nb, tbl[i].bits);

    // Hold in_valid with 0x01..0x06 and expect six contiguous frames.
    fork
      begin : pusher
        int  acc;
        bit  seen, took;
        acc = 0; seen = 1'b0;
        in_data = 8'h01; vld[0] = 1'b1;
        for (int cyc = 0; cyc < 400 && acc < 6; cyc++) begin
          took = rdy[0];
          @(negedge clk);
          if (took) begin
            acc++;
            if (acc == 6) vld[0] = 1'b0;
            else          in_data = 8'(acc + 1);
          end
          if (!rdy[0] && !seen) begin
            seen = 1'b1;
            check("full_after_5", acc, 5);
          end
        end
        vld[0] = 1'b0;
        check("all_pushed", acc, 6);
      end
      begin : watcher
        bit         found, fok;
        logic [9:0] fr;
        found = 1'b0;
        for (int w = 0; w < 10 && !found; w++) begin
          @(negedge clk);
          if (txw[0] === 1'b0) found = 1'b1;
        end
        check("b2b_start", found, 1);
        for (int f = 0; f < 6; f++) begin
          fr  = {1'b1, 8'(f + 1), 1'b0};
          fok = 1'b1;
          for (int b = 0; b < 10; b++)
            for (int c = 0; c < 4; c++) begin
              if (!(f == 0 && b == 0 && c == 0)) @(negedge clk);
              if (txw[0] !== fr[b] || be[0] !== 1'b1) fok = 1'b0;
            end
          check($sformatf("b2b_frame%0d", f), fok, 1);
        end
        @(negedge clk);
        check("b2b_end", {txw[0], be[0], bsy[0]}, 3'b100);
      end
    join

    // Reset during data bit 3 of 0x55 with a second byte still queued.
    push_raw(0, 8'h55);
    @(negedge clk);
    check("rst_pre_start", txw[0], 0);
    in_data = 8'h66; vld[0] = 1'b1;
    @(negedge clk); vld[0] = 1'b0;
    repeat (16) @(negedge clk);
    check("rst_bit3", {txw[0], be[0]}, 2'b01);
    #1 RST = 1'b1;
    #1 check("rst_async", {txw[0], be[0], bsy[0], rdy[0]}, 4'b1001);
    @(negedge clk); RST = 1'b0;
    ok = 1'b1;
    repeat (60) begin
      @(negedge clk);
      if (txw[0] !== 1'b1 || be[0] !== 1'b0 || bsy[0] !== 1'b0) ok = 1'b0;
    end
    check("rst_no_residual", ok, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
